hilo_muldiv: RTL and testbench



---
 rtl/hilo_muldiv_pkg.sv | 18 +
 rtl/muldiv_iter_core.sv | 64 ++++++
 rtl/hilo_muldiv.sv | 138 +++++++++++++
 tb/tb_hilo_muldiv.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: operation codes,
// FSM states and the zero word.
package hilo_muldiv_pkg;

    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } md_state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned iterative datapath: radix-2 shift-add multiply and restoring
// shift-subtract divide, one bit per step, with its own iteration counter.
module muldiv_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     a_mag,
    input  logic [WIDTH-1:0]     b_mag,
    output logic [2*WIDTH-1:0]   acc,
    output logic                 count_last
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0]   m_reg;
    logic               is_div_reg;
    logic [CW-1:0]      count_reg;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;

    // Multiply: low half holds the multiplier, upper half accumulates.
    // Divide: upper half is the partial remainder, low half shifts the
    // dividend out while quotient bits shift in.
    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, m_reg} : '0);
        div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, m_reg};
        if (is_div_reg) begin
            acc_next = {(div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                        acc_reg[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_reg    <= '0;
            m_reg      <= '0;
            is_div_reg <= 1'b0;
            count_reg  <= '0;
        end else if (load) begin
            acc_reg    <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
            m_reg      <= is_div ? b_mag : a_mag;
            is_div_reg <= is_div;
            count_reg  <= '0;
        end else if (step) begin
            acc_reg    <= acc_next;
            count_reg  <= count_reg + 1'b1;
        end
    end

    assign acc        = acc_reg;
    assign count_last = (count_reg == LAST);

endmodule

// File: rtl/hilo_muldiv.sv
// MIPS HI/LO multiply/divide unit: control FSM, sign fix-up, HI/LO
// registers and MTHI/MTLO around the iterative unsigned core.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               Start,
    input  logic [1:0]         Op,
    input  logic [WIDTH-1:0]   OperandA,
    input  logic [WIDTH-1:0]   OperandB,
    input  logic [1:0]         HiLoWrite,
    input  logic [WIDTH-1:0]   HiLoWriteData,
    output logic               Busy,
    output logic               Done,
    output logic               DivByZero,
    output logic [WIDTH-1:0]   Hi,
    output logic [WIDTH-1:0]   Lo
);

    md_state_t          state_reg, state_next;
    logic [1:0]         op_reg, op_next;
    logic               neg_q_reg, neg_q_next;
    logic               neg_r_reg, neg_r_next;
    logic               zero_reg, zero_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;
    logic               done_reg, done_next;
    logic               dbz_reg, dbz_next;

    logic               load, step, count_last;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] product;
    logic               signed_op, a_neg, b_neg, div_zero;
    logic [WIDTH-1:0]   a_mag, b_mag;

    // Magnitudes fit in WIDTH bits unsigned, so the most negative value
    // needs no special case.
    assign signed_op = (Op == MD_MULT) || (Op == MD_DIV);
    assign a_neg     = signed_op && OperandA[WIDTH-1];
    assign b_neg     = signed_op && OperandB[WIDTH-1];
    assign a_mag     = a_neg ? (~OperandA + 1'b1) : OperandA;
    assign b_mag     = b_neg ? (~OperandB + 1'b1) : OperandB;
    assign div_zero  = Op[1] && (OperandB == '0);
    assign product   = neg_q_reg ? (~acc + 1'b1) : acc;

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .step       (step),
        .is_div     (Op[1]),
        .a_mag      (a_mag),
        .b_mag      (b_mag),
        .acc        (acc),
        .count_last (count_last)
    );

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        neg_q_next = neg_q_reg;
        neg_r_next = neg_r_reg;
        zero_next  = zero_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        done_next  = 1'b0;
        dbz_next   = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (Start) begin
                    load       = 1'b1;
                    op_next    = Op;
                    neg_q_next = a_neg ^ b_neg;
                    neg_r_next = a_neg;
                    zero_next  = div_zero;
                    state_next = div_zero ? ST_FINISH : ST_RUN;
                end else begin
                    if (HiLoWrite[1]) hi_next = HiLoWriteData;
                    if (HiLoWrite[0]) lo_next = HiLoWriteData;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (count_last) state_next = ST_FINISH;
            end
            ST_FINISH: begin
                done_next  = 1'b1;
                state_next = ST_IDLE;
                if (zero_reg) begin
                    dbz_next = 1'b1;
                end else if (op_reg[1]) begin
                    lo_next = neg_q_reg ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
                    hi_next = neg_r_reg ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
                end else begin
                    hi_next = product[2*WIDTH-1:WIDTH];
                    lo_next = product[WIDTH-1:0];
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            op_reg    <= MD_MULT;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            zero_reg  <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            done_reg  <= 1'b0;
            dbz_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            neg_q_reg <= neg_q_next;
            neg_r_reg <= neg_r_next;
            zero_reg  <= zero_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            done_reg  <= done_next;
            dbz_reg   <= dbz_next;
        end
    end

    assign Busy      = (state_reg != ST_IDLE);
    assign Done      = done_reg;
    assign DivByZero = dbz_reg;
    assign Hi        = hi_reg;
    assign Lo        = lo_reg;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: operation results, latency, divide by
// zero, MTHI/MTLO, busy-time lockout and mid-operation reset.
module tb_hilo_muldiv;

    logic        clock = 1'b0;
    logic        reset;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] OperandA, OperandB;
    logic [1:0]  HiLoWrite;
    logic [31:0] HiLoWriteData;
    logic        Busy, Done, DivByZero;
    logic [31:0] Hi, Lo;

    int errors = 0;
    int checks = 0;

    hilo_muldiv #(.WIDTH(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .Start         (Start),
        .Op            (Op),
        .OperandA      (OperandA),
        .OperandB      (OperandB),
        .HiLoWrite     (HiLoWrite),
        .HiLoWriteData (HiLoWriteData),
        .Busy          (Busy),
        .Done          (Done),
        .DivByZero     (DivByZero),
        .Hi            (Hi),
        .Lo            (Lo)
    );

    always #5 clock = ~clock;

    // Drive Start for exactly one rising edge; returns at the falling edge after it.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        Start = 1'b1; Op = op; OperandA = a; OperandB = b;
        @(negedge clock);
        Start = 1'b0;
    endtask

    // Count falling edges until Done is seen, bounded at 40.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!Done && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; Start = 1'b0; Op = 2'd0; OperandA = '0; OperandB = '0;
        HiLoWrite = 2'b00; HiLoWriteData = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({Busy, Done, DivByZero} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b expected 000", {Busy, Done, DivByZero});
        end
        checks++;
        if ({Hi, Lo} !== 64'h0) begin
            errors++; $display("FAIL reset_hilo: got %h expected 0", {Hi, Lo});
        end
        $display("txn reset: Busy=%b Done=%b Hi=%h Lo=%h", Busy, Done, Hi, Lo);
    endtask

    // Runs one full operation and checks latency, results and pulse width.
    task automatic test_op(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        logic [31:0] hi_before;
        hi_before = Hi;
        launch(op, a, b);
        checks++;
        if (Busy !== 1'b1) begin
            errors++; $display("FAIL %s_busy: got %b expected 1", name, Busy);
        end
        repeat (10) @(negedge clock);
        checks++;
        if (Hi !== hi_before) begin
            errors++; $display("FAIL %s_hold: got %h expected %h", name, Hi, hi_before);
        end
        wait_done(cyc);
        cyc += 10;
        checks++;
        if (cyc !== 33) begin
            errors++; $display("FAIL %s_latency: got %0d expected 33", name, cyc);
        end
        checks++;
        if ({Hi, Lo, Busy, DivByZero} !== {exp_hi, exp_lo, 2'b00}) begin
            errors++; $display("FAIL %s_result: got hi=%h lo=%h busy=%b dbz=%b expected hi=%h lo=%h busy=0 dbz=0",
                               name, Hi, Lo, Busy, DivByZero, exp_hi, exp_lo);
        end
        $display("txn %s a=%h b=%h -> hi=%h lo=%h cycles=%0d", name, a, b, Hi, Lo, cyc);
        @(negedge clock);
        checks++;
        if (Done !== 1'b0) begin
            errors++; $display("FAIL %s_done_pulse: got %b expected 0", name, Done);
        end
    endtask

    task automatic test_mthi_divzero;
        int cyc;
        @(negedge clock);
        HiLoWrite = 2'b10; HiLoWriteData = 32'h1234_5678;
        @(negedge clock);
        HiLoWrite = 2'b00;
        checks++;
        if (Hi !== 32'h1234_5678) begin
            errors++; $display("FAIL mthi: got %h expected 12345678", Hi);
        end
        $display("txn mthi data=12345678 -> hi=%h", Hi);
        launch(2'd3, 32'd5, 32'd0);
        checks++;
        if ({Busy, Done} !== 2'b10) begin
            errors++; $display("FAIL divzero_busy: got %b expected 10", {Busy, Done});
        end
        wait_done(cyc);
        checks++;
        if ({cyc[7:0], Done, DivByZero, Busy, Hi} !== {8'd1, 3'b110, 32'h1234_5678}) begin
            errors++; $display("FAIL divzero: got cyc=%0d done=%b dbz=%b busy=%b hi=%h expected cyc=1 done=1 dbz=1 busy=0 hi=12345678",
                               cyc, Done, DivByZero, Busy, Hi);
        end
        $display("txn divu 5/0 -> dbz=%b hi=%h cycles=%0d", DivByZero, Hi, cyc);
        @(negedge clock);
        checks++;
        if ({Done, DivByZero} !== 2'b00) begin
            errors++; $display("FAIL divzero_pulse: got %b expected 00", {Done, DivByZero});
        end
        HiLoWrite = 2'b11; HiLoWriteData = 32'hCAFE_F00D;
        @(negedge clock);
        HiLoWrite = 2'b00;
        checks++;
        if ({Hi, Lo} !== {32'hCAFE_F00D, 32'hCAFE_F00D}) begin
            errors++; $display("FAIL mthilo: got %h expected cafef00dcafef00d", {Hi, Lo});
        end
        $display("txn mthi+mtlo data=cafef00d -> hi=%h lo=%h", Hi, Lo);
    endtask

    task automatic test_busy_ignore;
        int cyc;
        launch(2'd1, 32'd3, 32'd5);
        repeat (4) @(negedge clock);
        Start = 1'b1; Op = 2'd3; OperandA = 32'd100; OperandB = 32'd7;
        HiLoWrite = 2'b11; HiLoWriteData = 32'hDEAD_BEEF;
        @(negedge clock);
        Start = 1'b0; HiLoWrite = 2'b00;
        checks++;
        if ({Hi, Lo} !== {32'hCAFE_F00D, 32'hCAFE_F00D}) begin
            errors++; $display("FAIL busy_mt_ignored: got %h expected cafef00dcafef00d", {Hi, Lo});
        end
        wait_done(cyc);
        cyc += 5;
        checks++;
        if ({cyc[7:0], Hi, Lo} !== {8'd33, 32'd0, 32'd15}) begin
            errors++; $display("FAIL busy_ignore: got cyc=%0d hi=%h lo=%h expected cyc=33 hi=0 lo=f", cyc, Hi, Lo);
        end
        $display("txn multu 3*5 with ignored start/mt -> hi=%h lo=%h cycles=%0d", Hi, Lo, cyc);
    endtask

    task automatic test_back_to_back;
        int cyc;
        launch(2'd1, 32'd6, 32'd7);
        wait_done(cyc);
        Start = 1'b1; Op = 2'd3; OperandA = 32'd100; OperandB = 32'd7;
        @(negedge clock);
        Start = 1'b0;
        checks++;
        if ({Busy, Lo} !== {1'b1, 32'd42}) begin
            errors++; $display("FAIL back_to_back_start: got busy=%b lo=%h expected busy=1 lo=2a", Busy, Lo);
        end
        wait_done(cyc);
        checks++;
        if ({cyc[7:0], Hi, Lo} !== {8'd33, 32'd2, 32'd14}) begin
            errors++; $display("FAIL back_to_back: got cyc=%0d hi=%h lo=%h expected cyc=33 hi=2 lo=e", cyc, Hi, Lo);
        end
        $display("txn back-to-back divu 100/7 -> hi=%h lo=%h cycles=%0d", Hi, Lo, cyc);
    endtask

    task automatic test_reset_midop;
        int seen;
        launch(2'd0, 32'hFFFF_FFFF, 32'd2);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if ({Busy, Hi, Lo} !== 65'h0) begin
            errors++; $display("FAIL reset_midop: got busy=%b hi=%h lo=%h expected 0", Busy, Hi, Lo);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (Done) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL reset_stale_done: got %0d pulses expected 0", seen);
        end
        $display("txn reset during mult -> busy=%b hi=%h lo=%h stale_done=%0d", Busy, Hi, Lo, seen);
    endtask

    initial begin
        test_reset();
        test_op("mult",   2'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        test_op("multu",  2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE);
        test_op("div",    2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        test_op("divu",   2'd3, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003);
        test_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        test_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_000F);
        test_op("div_posneg", 2'd2, 32'h0000_0011, 32'hFFFF_FFFB, 32'h0000_0002, 32'hFFFF_FFFD);
        test_mthi_divzero();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
